// File: rtl/prim_secded_inv_39_32_dec_pipe.sv
// Decoder for inverted Hsiao SECDED(39,32) codewords. It un-inverts the word,
//   computes the syndrome, corrects single-bit data errors and flags double-bit errors.
// Latency is 2 cycles from input handshake to out_valid_o. Throughput is 1 word/cycle.
// Backpressure: the output holds until out_ready_i. in_ready_o is combinational from out_ready_i.
//
// Ports:
//   clk_i, rst_i             : clock and asynchronous active-high reset
//   in_valid_i/in_ready_o    : input handshake for cw_i (inverted codeword, [38:32] check)
//   out_valid_o/out_ready_i  : output handshake for data_o, syndrome_o, err_o {double, single}
//   cnt_clr_i                : synchronous clear of both event counters (wins over increment)
//   single_cnt_o/double_cnt_o: saturating counts of single/double error results accepted
module prim_secded_inv_39_32_dec_pipe #(
  parameter int CntW      = 16,
  parameter bit EnCorrect = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [38:0]     cw_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     data_o,
  output logic [6:0]      syndrome_o,
  output logic [1:0]      err_o,
  input  logic            cnt_clr_i,
  output logic [CntW-1:0] single_cnt_o,
  output logic [CntW-1:0] double_cnt_o
);

  // The encoder stores these check bits inverted, so a cleared memory does not decode as valid.
  localparam logic [38:0] InvMask = 39'h2A00000000;

  // Data-bit rows of the parity-check matrix, where HMat[k] is row k.
  localparam logic [6:0][31:0] HMat = {
    32'h98505586, 32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
    32'h413D89AA, 32'hDEBA8050, 32'h2606BD25
  };

  logic        s1_vld_q;
  logic [38:0] s1_u_q,   s1_u_d;
  logic [6:0]  s1_syn_q, s1_syn_d;

  logic        s2_vld_q;
  logic [31:0] s2_data_q, s2_data_d;
  logic [6:0]  s2_syn_q;
  logic [1:0]  s2_err_q,  s2_err_d;

  logic [CntW-1:0] single_cnt_q, single_cnt_d;
  logic [CntW-1:0] double_cnt_q, double_cnt_d;

  logic s2_adv, in_hs, out_hs;

  assign s2_adv     = ~s2_vld_q | out_ready_i;
  assign in_ready_o = ~s1_vld_q | s2_adv;
  assign in_hs      = in_valid_i & in_ready_o;
  assign out_hs     = s2_vld_q & out_ready_i;

  // Stage 1: un-invert the codeword and compute the syndrome.
  // Each check bit contributes to its own syndrome bit only.
  always_comb begin
    s1_u_d   = cw_i ^ InvMask;
    s1_syn_d = '0;
    for (int k = 0; k < 7; k++) begin
      s1_syn_d[k] = (^(s1_u_d[31:0] & HMat[k])) ^ s1_u_d[32+k];
    end
  end

  // Stage 2: correct the data and classify the error.
  // A data bit flips only when the syndrome equals that bit's column exactly.
  // Check-bit errors (one-hot syndrome) and odd syndromes that match no column
  // therefore leave the data unchanged.
  always_comb begin
    logic [6:0] col;
    s2_data_d = s1_u_q[31:0];
    col       = '0;
    for (int j = 0; j < 32; j++) begin
      for (int k = 0; k < 7; k++) begin
        col[k] = HMat[k][j];
      end
      if (EnCorrect && (s1_syn_q == col)) begin
        s2_data_d[j] = ~s1_u_q[j];
      end
    end
    s2_err_d = {(|s1_syn_q) & ~(^s1_syn_q), ^s1_syn_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s1_u_q   <= '0;
      s1_syn_q <= '0;
    end else if (in_hs) begin
      s1_vld_q <= 1'b1;
      s1_u_q   <= s1_u_d;
      s1_syn_q <= s1_syn_d;
    end else if (s2_adv) begin
      s1_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_syn_q  <= '0;
      s2_err_q  <= '0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_data_q <= s2_data_d;
        s2_syn_q  <= s1_syn_q;
        s2_err_q  <= s2_err_d;
      end
    end
  end

  // Counters count only the results that are accepted, so a held output is counted once.
  always_comb begin
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    if (cnt_clr_i) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end else if (out_hs) begin
      if (s2_err_q[0] && (single_cnt_q != '1)) single_cnt_d = single_cnt_q + CntW'(1);
      if (s2_err_q[1] && (double_cnt_q != '1)) double_cnt_d = double_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign out_valid_o  = s2_vld_q;
  assign data_o       = s2_data_q;
  assign syndrome_o   = s2_syn_q;
  assign err_o        = s2_err_q;
  assign single_cnt_o = single_cnt_q;
  assign double_cnt_o = double_cnt_q;

endmodule

// File: tb/tb_prim_secded_inv_39_32_dec_pipe.sv
// Bench for the inverted SECDED(39,32) decoder pipeline. Two instances share the stimulus:
// instance a uses the default parameters, and instance b uses CntW=2 with correction off.
// A behavioural reference model computes the expected results.
module tb_prim_secded_inv_39_32_dec_pipe;

  localparam logic [38:0] INV = 39'h2A00000000;
  localparam bit [31:0] HM [7] = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
                                   32'hC2C1323B, 32'h2DCC624C, 32'h98505586};

  typedef struct packed {
    logic [31:0] data;
    logic [6:0]  syn;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [38:0] cw = '0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_data, b_data;
  logic [6:0]  a_syn, b_syn;
  logic [1:0]  a_err, b_err;
  logic [15:0] a_scnt, a_dcnt;
  logic [1:0]  b_scnt, b_dcnt;

  int total = 0;
  int bad   = 0;
  exp_t qa[$];
  exp_t qb[$];
  int ma_s = 0, ma_d = 0, mb_s = 0, mb_d = 0;

  always #5 clk = ~clk;

  prim_secded_inv_39_32_dec_pipe u_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready), .cw_i(cw),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .data_o(a_data), .syndrome_o(a_syn),
    .err_o(a_err), .cnt_clr_i(cnt_clr), .single_cnt_o(a_scnt), .double_cnt_o(a_dcnt)
  );

  prim_secded_inv_39_32_dec_pipe #(.CntW(2), .EnCorrect(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready), .cw_i(cw),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .data_o(b_data), .syndrome_o(b_syn),
    .err_o(b_err), .cnt_clr_i(cnt_clr), .single_cnt_o(b_scnt), .double_cnt_o(b_dcnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decoder. It forms the syndrome as the parity of the codeword against each
  // matrix row. It then flips the data bit whose column equals the syndrome, if correction is on.
  function automatic exp_t model(input logic [38:0] c, input bit enc);
    exp_t r;
    logic [38:0] u;
    logic [6:0] col;
    u = c ^ INV;
    for (int k = 0; k < 7; k++) r.syn[k] = (^(u[31:0] & HM[k])) ^ u[32+k];
    r.data = u[31:0];
    for (int j = 0; j < 32; j++) begin
      for (int k = 0; k < 7; k++) col[k] = HM[k][j];
      if (enc && r.syn == col) r.data[j] = ~r.data[j];
    end
    r.err = {(r.syn != 7'd0) && !(^r.syn), ^r.syn};
    return r;
  endfunction

  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] u;
    u[31:0] = d;
    for (int k = 0; k < 7; k++) u[32+k] = ^(d & HM[k]);
    return u ^ INV;
  endfunction

  function automatic logic [38:0] rand_cw();
    logic [38:0] c;
    int p, q, mode;
    c = encode($urandom);
    mode = $urandom_range(0, 3);
    p = $urandom_range(0, 38);
    q = (p + 1 + $urandom_range(0, 37)) % 39;
    if (mode >= 1) c[p] = ~c[p];
    if (mode == 2) c[q] = ~c[q];
    if (mode == 3) c = {7'($urandom), 32'($urandom)};
    return c;
  endfunction

  // One clock cycle. Handshakes are taken from the inputs as already driven and from the
  // outputs as settled before the edge. Counters are checked just after the edge.
  task automatic cycle(output bit acc);
    exp_t e;
    bit clr;
    #1;
    acc = in_valid & a_in_ready;
    clr = cnt_clr;
    if (a_out_valid & out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_out", 64'(a_out_valid), 64'd0);
      else begin
        e = qa.pop_front();
        chk("a_data", 64'(a_data), 64'(e.data));
        chk("a_syn", 64'(a_syn), 64'(e.syn));
        chk("a_err", 64'(a_err), 64'(e.err));
        if (!clr && e.err[0] && ma_s < 65535) ma_s++;
        if (!clr && e.err[1] && ma_d < 65535) ma_d++;
      end
    end
    if (b_out_valid & out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_out", 64'(b_out_valid), 64'd0);
      else begin
        e = qb.pop_front();
        chk("b_data", 64'(b_data), 64'(e.data));
        chk("b_syn", 64'(b_syn), 64'(e.syn));
        chk("b_err", 64'(b_err), 64'(e.err));
        if (!clr && e.err[0] && mb_s < 3) mb_s++;
        if (!clr && e.err[1] && mb_d < 3) mb_d++;
      end
    end
    if (clr) begin ma_s = 0; ma_d = 0; mb_s = 0; mb_d = 0; end
    if (acc) begin
      qa.push_back(model(cw, 1'b1));
      qb.push_back(model(cw, 1'b0));
    end
    @(posedge clk);
    #1;
    chk("a_single_cnt", 64'(a_scnt), 64'(ma_s));
    chk("a_double_cnt", 64'(a_dcnt), 64'(ma_d));
    chk("b_single_cnt", 64'(b_scnt), 64'(mb_s));
    chk("b_double_cnt", 64'(b_dcnt), 64'(mb_d));
  endtask

  // Send one word into the empty pipe with no backpressure. Check the 2-cycle latency and the
  // expected values for this word, then let it drain.
  task automatic send_check(input string tag, input logic [38:0] c, input logic [6:0] syn,
                            input logic [1:0] err, input logic [31:0] da, input logic [31:0] db);
    bit acc;
    out_ready = 1'b1;
    in_valid = 1'b1;
    cw = c;
    cycle(acc);
    chk({tag, "_accept"}, 64'(acc), 64'd1);
    in_valid = 1'b0;
    chk({tag, "_vld_lat1"}, 64'(a_out_valid), 64'd0);
    cycle(acc);
    chk({tag, "_vld_lat2"}, 64'(a_out_valid), 64'd1);
    chk({tag, "_syn"}, 64'(a_syn), 64'(syn));
    chk({tag, "_err"}, 64'(a_err), 64'(err));
    chk({tag, "_data_a"}, 64'(a_data), 64'(da));
    chk({tag, "_data_b"}, 64'(b_data), 64'(db));
    cycle(acc);
  endtask

  initial begin
    bit acc;
    int n, sent;
    logic [38:0] words [5];

    // Reset values.
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_data", 64'(a_data), 64'd0);
    chk("rst_syn", 64'(a_syn), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_cnt", 64'({a_scnt, a_dcnt}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);

    // Directed words, with expected values taken directly from the decoding rules.
    send_check("clean",  39'h2A00000000, 7'h00, 2'b00, 32'h0, 32'h0);
    send_check("bit0",   39'h2A00000001, 7'h19, 2'b01, 32'h0, 32'h1);
    send_check("bit01",  39'h2A00000003, 7'h4D, 2'b10, 32'h3, 32'h3);
    send_check("chk32",  39'h2B00000000, 7'h01, 2'b01, 32'h0, 32'h0);

    // Backpressure: with the consumer stalled for 4 cycles, only 2 words fit in the pipe.
    for (int i = 0; i < 5; i++) words[i] = rand_cw();
    out_ready = 1'b0;
    in_valid = 1'b1;
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      cw = words[sent];
      cycle(acc);
      if (acc) sent++;
    end
    chk("bp_accepts", 64'(sent), 64'd2);
    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp_hold_vld", 64'(a_out_valid), 64'd1);
    out_ready = 1'b1;
    n = 0;
    while (sent < 5 && n < 20) begin
      cw = words[sent];
      cycle(acc);
      if (acc) sent++;
      n++;
    end
    chk("bp_all_sent", 64'(sent), 64'd5);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle(acc);
    chk("bp_drained", 64'(qa.size()), 64'd0);

    // Saturation of the 2-bit counters, then a clear that coincides with a 6th single error.
    for (int i = 0; i < 5; i++) send_check("sat", 39'h2A00000001, 7'h19, 2'b01, 32'h0, 32'h1);
    chk("sat_b_single", 64'(b_scnt), 64'd3);
    in_valid = 1'b1;
    cw = 39'h2A00000001;
    cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
    chk("clr_vld", 64'(a_out_valid), 64'd1);
    cnt_clr = 1'b1;
    cycle(acc);
    cnt_clr = 1'b0;
    chk("clr_b_single", 64'(b_scnt), 64'd0);
    chk("clr_a_single", 64'(a_scnt), 64'd0);

    // Random traffic with random stalls and occasional clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      cw        = rand_cw();
      cycle(acc);
    end
    cnt_clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc);
    chk("rand_drained", 64'(qa.size() + qb.size()), 64'd0);

    // Reset with 2 words in flight. Both words are discarded.
    out_ready = 1'b0;
    in_valid = 1'b1;
    cw = rand_cw();
    cycle(acc);
    cw = rand_cw();
    cycle(acc);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld_a", 64'(a_out_valid), 64'd0);
    chk("mid_rst_vld_b", 64'(b_out_valid), 64'd0);
    qa.delete(); qb.delete();
    ma_s = 0; ma_d = 0; mb_s = 0; mb_d = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      chk("post_rst_no_out", 64'(a_out_valid | b_out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prim_secded_inv_39_32_dec_pipe.md
Name: prim_secded_inv_39_32_dec_pipe

Overview:
- Pipelined, flow-controlled decoder for inverted Hsiao SECDED(39,32) codewords, as produced by the team's inverted 39/32 encoder.
- Sits directly downstream of that encoder's storage, on the read path of ECC-protected SRAM/register banks.
- Un-inverts each codeword, computes the 7-bit syndrome, corrects single-bit errors and flags double-bit errors.
- Keeps saturating single-error and double-error event counters for alert/telemetry logic.

Parameters:
- CntW, 16, width of each saturating error counter (legal range 1..32).
- EnCorrect, 1, when 1, single-bit errors are corrected on data_o; when 0, data_o is raw codeword bits [31:0] after un-inversion.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- in_valid_i  input  1  codeword valid
- in_ready_o  output  1  decoder can accept codeword
- cw_i  input  39  inverted codeword (bits 31:0 data, 38:32 check)
- out_valid_o  output  1  decoded result valid
- out_ready_i  input  1  consumer accepts result
- data_o  output  32  decoded data
- syndrome_o  output  7  syndrome of this codeword
- err_o  output  2  {double_err, single_err}
- cnt_clr_i  input  1  synchronous clear of both counters
- single_cnt_o  output  CntW  saturating count of single-error results
- double_cnt_o  output  CntW  saturating count of double-error results

Behaviour:
- Reset and clock: one clock. Reset is asynchronous and active-high on rst_i; it clears all pipeline valids and all registers.
- Reset values: out_valid_o=0, data_o=0, syndrome_o=0, err_o=0, both counters=0. in_ready_o=1 once reset deasserts.
- Reset mid-operation: in-flight words are discarded and never emitted.
- Un-inversion: u = cw_i ^ 39'h2A00000000.
- Syndrome: s[k] = ^(u & (M_k | (1 << (32+k)))), with:
  - M_0=0x2606BD25, M_1=0xDEBA8050, M_2=0x413D89AA, M_3=0x31234ED1
  - M_4=0xC2C1323B, M_5=0x2DCC624C, M_6=0x98505586
- Data column j: the 7-bit vector {M_6[j],...,M_0[j]}. Each column has odd weight.
- Classification:
  - single_err = ^s (odd syndrome weight).
  - double_err = (s != 0) & ~^s.
  - A single error whose syndrome matches no column and is not one-hot is still flagged single_err. No data bit is flipped in that case.
- Correction: data_o[j] = u[j] ^ (EnCorrect & (s == column j)). A one-hot syndrome (check-bit error) leaves data unchanged.
- Pipeline stages:
  - S1 registers u and s on input handshake (in_valid_i & in_ready_o).
  - S2 registers corrected data, syndrome and err.
  - Latency is 2 cycles from handshake to out_valid_o with no backpressure. Throughput is 1 word/cycle.
- Flow control:
  - S2 advances when ~out_valid_o | out_ready_i.
  - S1 advances into S2 when S1 is valid and S2 advances.
  - in_ready_o = ~s1_valid | s2_adv. This is combinational from out_ready_i.
  - With out_ready_i=0 and both stages full, in_ready_o=0. Outputs hold stable until accepted. No word is dropped or duplicated.
- Counters:
  - Increment once per output handshake (out_valid_o & out_ready_i) carrying the corresponding flag.
  - Saturate at 2^CntW-1; no wrap-around.
  - cnt_clr_i has priority over a simultaneous increment: the result is 0 and that event is lost.

Test Plan:
- Clean word: cw_i=39'h2A00000000 -> 2 cycles later data_o=0, syndrome_o=0, err_o=2'b00, counters unchanged.
- Data bit 0 flipped: cw_i=39'h2A00000001 -> syndrome_o=7'h19, err_o=2'b01, data_o=0, single_cnt_o increments by 1. With EnCorrect=0, data_o=1.
- Data bits 0 and 1 flipped: cw_i=39'h2A00000003 -> syndrome_o=7'h4D, err_o=2'b10, double_cnt_o increments by 1.
- Check bit 32 flipped: cw_i=39'h2B00000000 -> syndrome_o=7'h01, err_o=2'b01, data_o=0.
- Backpressure: stream 5 words with out_ready_i held low for 4 cycles -> in_ready_o drops after 2 accepts; all 5 results emerge in order, each exactly once.
- Counter saturation: with CntW=2, apply 5 single-error words -> single_cnt_o=3. Pulse cnt_clr_i together with a 6th single error -> counter reads 0.
- Reset mid-operation: assert rst_i with 2 words in flight -> out_valid_o=0 immediately; nothing is emitted after release.
